// File: rtl/rf68000_irq_server.sv
// Interrupt-ring server node: captures packets addressed to ID, queues them,
// and re-dispatches them round-robin to enabled cores through empty ring slots.

package nic_pkg;
  typedef struct packed {
    logic [5:0] did;
    logic [5:0] sid;
    logic [5:0] age;
    logic       firq;
    logic [2:0] irq;
    logic [7:0] cause;
  } ipacket_t;

  typedef struct packed {
    logic [5:0] sid;
    logic       firq;
    logic [2:0] irq;
    logic [7:0] cause;
  } irq_entry_t;
endpackage

module rf68000_irq_server
  import nic_pkg::*;
#(
  parameter logic [5:0]  ID      = 6'd61,
  parameter int unsigned NCORES  = 8,
  parameter int unsigned QDEPTH  = 8,
  parameter logic [5:0]  MAX_AGE = 6'd48
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  ipacket_t                     ipacket_i,
  output ipacket_t                     ipacket_o,
  input  logic [NCORES-1:0]            core_mask_i,
  output logic [$clog2(QDEPTH+1)-1:0]  pending_o,
  output logic                         overflow_o,
  output logic                         drop_o
);

  localparam int unsigned PW  = $clog2(QDEPTH);
  localparam int unsigned CW  = $clog2(QDEPTH + 1);
  localparam int unsigned RW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned RW1 = RW + 1;

  irq_entry_t mem [QDEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [RW-1:0] rr_q, rr_d;

  irq_entry_t entry_in, last_entry, head_entry;
  ipacket_t   pkt_d;
  logic       push, pop, overflow_d, drop_d;
  logic       full, dup, found;
  logic [RW-1:0]  sel;
  logic [RW1-1:0] idx;

  assign entry_in   = '{sid: ipacket_i.sid, firq: ipacket_i.firq,
                        irq: ipacket_i.irq, cause: ipacket_i.cause};
  assign last_entry = mem[PW'(wptr_q - 1'b1)];
  assign head_entry = mem[rptr_q];
  assign full       = (count_q == CW'(QDEPTH));
  // Last-written entry is still queued whenever the FIFO is non-empty.
  assign dup        = (count_q != '0) && (entry_in == last_entry);

  // Circular first-set search of core_mask_i starting at rr_q
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NCORES; i++) begin
      idx = RW1'({1'b0, rr_q}) + RW1'(i);
      if (idx >= RW1'(NCORES)) idx = idx - RW1'(NCORES);
      if (!found && core_mask_i[idx[RW-1:0]]) begin
        found = 1'b1;
        sel   = idx[RW-1:0];
      end
    end
  end

  // Output slot selection: capture > scrub > pass > dispatch > empty
  always_comb begin
    pkt_d      = ipacket_i;
    push       = 1'b0;
    pop        = 1'b0;
    overflow_d = 1'b0;
    drop_d     = 1'b0;
    rr_d       = rr_q;
    if (ipacket_i.did == ID) begin
      if (!ipacket_i.firq && ipacket_i.irq == 3'd0) begin
        pkt_d = '0;
      end else if (dup) begin
        pkt_d = '0;
      end else if (!full) begin
        push  = 1'b1;
        pkt_d = '0;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (ipacket_i.did != 6'd0) begin
      if (ipacket_i.age >= MAX_AGE) begin
        pkt_d  = '0;
        drop_d = 1'b1;
      end else if (ipacket_i.age != 6'd63) begin
        pkt_d.age = ipacket_i.age + 6'd1;
      end
    end else if (count_q != '0 && found) begin
      pop         = 1'b1;
      pkt_d.did   = 6'(sel) + 6'd1;
      pkt_d.sid   = ID;
      pkt_d.age   = 6'd0;
      pkt_d.firq  = head_entry.firq;
      pkt_d.irq   = head_entry.irq;
      pkt_d.cause = head_entry.cause;
      rr_d        = (32'(sel) == NCORES - 1) ? '0 : RW'(sel + 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ipacket_o  <= '0;
      overflow_o <= 1'b0;
      drop_o     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rr_q       <= '0;
    end else begin
      ipacket_o  <= pkt_d;
      overflow_o <= overflow_d;
      drop_o     <= drop_d;
      rr_q       <= rr_d;
      if (push) begin
        wptr_q  <= PW'(wptr_q + 1'b1);
        count_q <= count_q + 1'b1;
      end else if (pop) begin
        rptr_q  <= PW'(rptr_q + 1'b1);
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem[wptr_q] <= entry_in;
  end

  assign pending_o = count_q;

endmodule

// File: tb/tb_rf68000_irq_server.sv
// Directed self-checking bench for rf68000_irq_server.

module tb_rf68000_irq_server;
  import nic_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  ipacket_t    ipacket_i, ipacket_o;
  logic [7:0]  core_mask_i;
  logic [3:0]  pending_o;
  logic        overflow_o, drop_o;

  int n_cmp = 0;
  int n_bad = 0;

  rf68000_irq_server dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ipacket_i   (ipacket_i),
    .ipacket_o   (ipacket_o),
    .core_mask_i (core_mask_i),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o),
    .drop_o      (drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic ipacket_t mk(input logic [5:0] did, input logic [5:0] sid,
                                  input logic [5:0] age, input logic firq,
                                  input logic [2:0] irq, input logic [7:0] cause);
    ipacket_t p;
    p.did = did; p.sid = sid; p.age = age; p.firq = firq; p.irq = irq; p.cause = cause;
    return p;
  endfunction

  task automatic cyc(input ipacket_t p);
    ipacket_i = p;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc('0);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    ipacket_i   = '0;
    core_mask_i = 8'hFF;

    // Reset state
    do_reset();
    chk("rst_pkt", 32'(ipacket_o), 32'd0);
    chk("rst_pending", 32'(pending_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);

    // Capture then dispatch
    cyc(mk(6'd61, 6'd3, 6'd0, 1'b0, 3'd5, 8'h40));
    chk("cap_pkt", 32'(ipacket_o), 32'd0);
    chk("cap_pending", 32'(pending_o), 32'd1);
    cyc('0);
    chk("disp_pkt", 32'(ipacket_o), 32'(mk(6'd1, 6'd61, 6'd0, 1'b0, 3'd5, 8'h40)));
    chk("disp_pending", 32'(pending_o), 32'd0);
    cyc(mk(6'd61, 6'd4, 6'd0, 1'b1, 3'd1, 8'h02));
    cyc('0);
    chk("disp_rr1", 32'(ipacket_o), 32'(mk(6'd2, 6'd61, 6'd0, 1'b1, 3'd1, 8'h02)));

    // Round-robin with a sparse mask
    do_reset();
    core_mask_i = 8'b0010_0100;
    cyc(mk(6'd61, 6'd1, 6'd0, 1'b0, 3'd1, 8'h11));
    cyc(mk(6'd61, 6'd2, 6'd0, 1'b0, 3'd2, 8'h22));
    cyc(mk(6'd61, 6'd3, 6'd0, 1'b0, 3'd3, 8'h33));
    chk("rr_pending", 32'(pending_o), 32'd3);
    cyc('0);
    chk("rr_d0", 32'(ipacket_o), 32'(mk(6'd3, 6'd61, 6'd0, 1'b0, 3'd1, 8'h11)));
    cyc('0);
    chk("rr_d1", 32'(ipacket_o), 32'(mk(6'd6, 6'd61, 6'd0, 1'b0, 3'd2, 8'h22)));
    cyc('0);
    chk("rr_d2", 32'(ipacket_o), 32'(mk(6'd3, 6'd61, 6'd0, 1'b0, 3'd3, 8'h33)));
    chk("rr_empty", 32'(pending_o), 32'd0);
    cyc('0);
    chk("rr_idle", 32'(ipacket_o), 32'd0);

    // Overflow with all cores masked off
    do_reset();
    core_mask_i = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cyc(mk(6'd61, 6'd9, 6'd0, 1'b0, 3'd4, 8'(i)));
      chk("ovf_fill_pending", 32'(pending_o), 32'(i + 1));
      chk("ovf_fill_flag", 32'(overflow_o), 32'd0);
    end
    cyc(mk(6'd61, 6'd9, 6'd7, 1'b0, 3'd4, 8'h88));
    chk("ovf_pass", 32'(ipacket_o), 32'(mk(6'd61, 6'd9, 6'd7, 1'b0, 3'd4, 8'h88)));
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_pending", 32'(pending_o), 32'd8);
    cyc('0);
    chk("ovf_flag_clr", 32'(overflow_o), 32'd0);
    chk("ovf_hold_pkt", 32'(ipacket_o), 32'd0);
    chk("ovf_hold_pending", 32'(pending_o), 32'd8);

    // Duplicate and null filtering
    do_reset();
    for (int i = 0; i < 4; i++) cyc(mk(6'd61, 6'd2, 6'd0, 1'b0, 3'd3, 8'd1));
    chk("dup_pending", 32'(pending_o), 32'd1);
    chk("dup_pkt", 32'(ipacket_o), 32'd0);
    cyc(mk(6'd61, 6'd2, 6'd0, 1'b0, 3'd0, 8'd1));
    chk("null_pkt", 32'(ipacket_o), 32'd0);
    chk("null_pending", 32'(pending_o), 32'd1);
    cyc(mk(6'd61, 6'd2, 6'd0, 1'b0, 3'd3, 8'd2));
    chk("nondup_pending", 32'(pending_o), 32'd2);

    // Aging and scrub
    cyc(mk(6'd5, 6'd7, 6'd10, 1'b0, 3'd2, 8'h09));
    chk("age_pkt", 32'(ipacket_o), 32'(mk(6'd5, 6'd7, 6'd11, 1'b0, 3'd2, 8'h09)));
    cyc(mk(6'd5, 6'd7, 6'd47, 1'b0, 3'd2, 8'h09));
    chk("age_47", 32'(ipacket_o), 32'(mk(6'd5, 6'd7, 6'd48, 1'b0, 3'd2, 8'h09)));
    chk("age_47_drop", 32'(drop_o), 32'd0);
    cyc(mk(6'd5, 6'd7, 6'd48, 1'b0, 3'd2, 8'h09));
    chk("scrub_pkt", 32'(ipacket_o), 32'd0);
    chk("scrub_drop", 32'(drop_o), 32'd1);
    cyc(mk(6'd63, 6'd1, 6'd0, 1'b1, 3'd0, 8'h55));
    chk("bcast_pkt", 32'(ipacket_o), 32'(mk(6'd63, 6'd1, 6'd1, 1'b1, 3'd0, 8'h55)));
    chk("scrub_drop_clr", 32'(drop_o), 32'd0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) cyc(mk(6'd61, 6'd1, 6'd0, 1'b0, 3'd6, 8'(8'h70 + i)));
    chk("mid_pending", 32'(pending_o), 32'd4);
    do_reset();
    chk("mid_rst_pending", 32'(pending_o), 32'd0);
    chk("mid_rst_pkt", 32'(ipacket_o), 32'd0);
    core_mask_i = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc('0);
      chk("mid_no_disp", 32'(ipacket_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
